// File: rtl/dnf_cfg_pkg.sv
// Shared types and constants for the config RAM command-frame decoder:
// header layout, opcodes, FSM states and error codes.
package dnf_cfg_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        DATA_HI,
        DATA_LO,
        WRITE,
        READ,
        READ_WAIT
    } state_t;

    localparam logic [1:0] ERR_ZERO_MASK = 2'b00;
    localparam logic [1:0] ERR_RSVD_OP   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
    localparam logic [1:0] ERR_OVERRUN   = 2'b11;

    localparam int HDR_OP_MSB   = 15;
    localparam int HDR_OP_LSB   = 14;
    localparam int HDR_RSV_MSB  = 13;
    localparam int HDR_RSV_LSB  = 12;
    localparam int HDR_MASK_MSB = 11;
    localparam int HDR_MASK_LSB = 8;
    localparam int HDR_ADDR_MSB = 7;
    localparam int HDR_ADDR_LSB = 0;

    // Words read by the filter top.
    localparam logic [7:0] ALPHA_ADDR  = 8'd0;
    localparam logic [7:0] ENABLE_ADDR = 8'd1;

endpackage

// File: rtl/cfg_frame_timer.sv
// Inter-word timeout counter: counts enabled cycles since the last clear and
// flags the cycle on which the count would reach TIMEOUT_CYCLES-1.
module cfg_frame_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/config_ram_writer.sv
// Decodes 16-bit command frames from spi_rx into DFFRAM256x32 write and
// readback strobes; all outputs are registered.
module config_ram_writer
    import dnf_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        wr_done,
    output logic        busy,
    output logic        err_valid,
    output logic [1:0]  err_code
);
    state_t      state, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] hi_q, hi_d;

    logic        ram_en_d, rd_valid_d, wr_done_d, err_valid_d;
    logic [3:0]  ram_we_d;
    logic [7:0]  ram_addr_d;
    logic [31:0] ram_din_d, rd_data_d;
    logic [1:0]  err_code_d;

    opcode_t     hdr_op;
    logic [3:0]  hdr_mask;
    logic [7:0]  hdr_addr;
    logic        in_frame, expire, unused_rsv;

    assign hdr_op   = opcode_t'(rx_data[HDR_OP_MSB:HDR_OP_LSB]);
    assign hdr_mask = rx_data[HDR_MASK_MSB:HDR_MASK_LSB];
    assign hdr_addr = rx_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
    // Reserved header bits carry no meaning; frames are decoded as if they were 0.
    assign unused_rsv = ^rx_data[HDR_RSV_MSB:HDR_RSV_LSB];
    assign in_frame = (state == DATA_HI) || (state == DATA_LO);

    cfg_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_frame || rx_valid),
        .enable (in_frame && !rx_valid),
        .expire (expire)
    );

    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        mask_d      = mask_q;
        hi_d        = hi_q;
        ram_en_d    = 1'b0;
        ram_we_d    = '0;
        ram_addr_d  = ram_addr;
        ram_din_d   = ram_din;
        rd_data_d   = rd_data;
        rd_valid_d  = 1'b0;
        wr_done_d   = 1'b0;
        err_valid_d = 1'b0;
        err_code_d  = err_code;

        case (state)
            IDLE: if (rx_valid) begin
                unique case (hdr_op)
                    OP_NOP: ;
                    OP_WRITE: if (hdr_mask == 4'b0) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_ZERO_MASK;
                    end else begin
                        addr_d  = hdr_addr;
                        mask_d  = hdr_mask;
                        state_d = DATA_HI;
                    end
                    OP_READ: begin
                        ram_en_d   = 1'b1;
                        ram_addr_d = hdr_addr;
                        state_d    = READ;
                    end
                    OP_RSVD: begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_RSVD_OP;
                    end
                endcase
            end
            DATA_HI, DATA_LO: if (rx_valid) begin
                if (state == DATA_HI) begin
                    hi_d    = rx_data;
                    state_d = DATA_LO;
                end else begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = mask_q;
                    ram_addr_d = addr_q;
                    ram_din_d  = {hi_q, rx_data};
                    wr_done_d  = 1'b1;
                    state_d    = WRITE;
                end
            end else if (expire) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_TIMEOUT;
                state_d     = IDLE;
            end
            WRITE, READ, READ_WAIT: begin
                state_d = (state == READ) ? READ_WAIT : IDLE;
                if (state == READ_WAIT) begin
                    rd_data_d  = ram_dout;
                    rd_valid_d = 1'b1;
                end
                // The RAM access in progress finishes; the extra word is dropped.
                if (rx_valid) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            mask_q    <= '0;
            hi_q      <= '0;
            ram_en    <= 1'b0;
            ram_we    <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            wr_done   <= 1'b0;
            busy      <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= '0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            hi_q      <= hi_d;
            ram_en    <= ram_en_d;
            ram_we    <= ram_we_d;
            ram_addr  <= ram_addr_d;
            ram_din   <= ram_din_d;
            rd_data   <= rd_data_d;
            rd_valid  <= rd_valid_d;
            wr_done   <= wr_done_d;
            busy      <= (state_d != IDLE);
            err_valid <= err_valid_d;
            err_code  <= err_code_d;
        end
    end

endmodule
